// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC processing-element family.
// The clamp and lane-priority helpers are written width-agnostic so sibling PEs can reuse them.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } mac_drain_state_t;

  localparam int SAT_MAX_W  = 64;
  localparam int PRI_MAX_CH = 32;

  // Operands arrive sign-extended to SAT_MAX_W; result is clamped or wrapped to a width-bit signed range.
  function automatic logic signed [SAT_MAX_W-1:0] sat_add(
    input logic signed [SAT_MAX_W-1:0] a,
    input logic signed [SAT_MAX_W-1:0] b,
    input logic                        sat_en,
    input int unsigned                 width
  );
    logic signed [SAT_MAX_W-1:0] sum;
    logic signed [SAT_MAX_W-1:0] max_v;
    logic signed [SAT_MAX_W-1:0] min_v;
    sum   = a + b;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (sat_en) begin
      if (sum > max_v)      sum = max_v;
      else if (sum < min_v) sum = min_v;
    end else begin
      sum = (sum <<< (SAT_MAX_W - width)) >>> (SAT_MAX_W - width);
    end
    return sum;
  endfunction

  // Lowest set bit wins; returns 0 when nothing is set.
  function automatic int pri_lowest(input logic [PRI_MAX_CH-1:0] v);
    int idx;
    idx = 0;
    for (int i = PRI_MAX_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Stage-2 accumulate: adds a signed product into a signed accumulator with optional clamp.
// Kept as its own module so the adder/clamp can be exercised in isolation.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int ACC_W  = 24,
  parameter int PROD_W = 16
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [PROD_W-1:0] prod,
  input  logic                     sat_en,
  output logic signed [ACC_W-1:0]  sum
);

  logic signed [SAT_MAX_W-1:0] acc_x;
  logic signed [SAT_MAX_W-1:0] prod_x;
  logic signed [SAT_MAX_W-1:0] sum_x;
  logic                        sum_unused;

  assign acc_x      = {{(SAT_MAX_W-ACC_W){acc[ACC_W-1]}}, acc};
  assign prod_x     = {{(SAT_MAX_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign sum_x      = sat_add(acc_x, prod_x, sat_en, ACC_W);
  assign sum        = sum_x[ACC_W-1:0];
  // Upper bits are only a sign extension of the truncated result.
  assign sum_unused = ^sum_x[SAT_MAX_W-1:ACC_W];

endmodule

// File: rtl/mac_pe_bank.sv
// Systolic MAC grid node: priority lane select, registered product, banked saturating accumulators
// and a handshaked drain engine that streams every accumulator out after a tile.
//
//   state | meaning
//   IDLE  | accepting MAC ops, drain engine parked
//   FLUSH | drain requested, waiting for the in-flight stage-1 op to land
//   DRAIN | presenting acc[cnt] on drain_data until every bank entry is accepted
module mac_pe_bank
  import mac_pkg::*;
#(
  parameter int W            = 8,
  parameter int ACC_W        = 24,
  parameter int NUM_CH       = 3,
  parameter int NUM_ACC      = 8,
  parameter int CLR_ON_DRAIN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          valid_ctrl,
  input  logic [NUM_CH*W-1:0]        a_in,
  input  logic signed [W-1:0]        weight,
  input  logic                       weight_valid_in,
  input  logic [$clog2(NUM_ACC)-1:0] acc_sel,
  input  logic                       sat_en,
  input  logic                       clear,
  input  logic                       drain_start,
  input  logic                       drain_ready,
  output logic [NUM_CH*W-1:0]        a_out,
  output logic signed [ACC_W-1:0]    acc_out,
  output logic                       valid_out,
  output logic signed [ACC_W-1:0]    drain_data,
  output logic [$clog2(NUM_ACC)-1:0] drain_idx,
  output logic                       drain_valid,
  output logic                       busy
);

  localparam int               SEL_W    = $clog2(NUM_ACC);
  localparam int               PROD_W   = 2 * W;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_ACC - 1);

  logic signed [ACC_W-1:0]  acc_q [NUM_ACC];
  logic signed [PROD_W-1:0] prod1;
  logic [SEL_W-1:0]         sel1;
  logic                     sat1;
  logic                     v1;
  mac_drain_state_t         state;
  logic [SEL_W-1:0]         cnt;

  logic                     do_mac;
  int                       lane_idx;
  logic signed [W-1:0]      lane_a;
  logic signed [W-1:0]      w_eff;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  sum2;
  logic                     drain_fire;

  always_comb begin
    lane_idx = pri_lowest(PRI_MAX_CH'(valid_ctrl));
    lane_a   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (lane_idx == k) lane_a = a_in[k*W +: W];
    end
    w_eff  = weight_valid_in ? weight : '0;
    prod_c = PROD_W'(lane_a) * PROD_W'(w_eff);
    do_mac = (|valid_ctrl) && !busy && !clear;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out <= '0;
      prod1 <= '0;
      sel1  <= '0;
      sat1  <= 1'b0;
      v1    <= 1'b0;
    end else begin
      a_out <= a_in;
      v1    <= do_mac;
      if (do_mac) begin
        prod1 <= prod_c;
        sel1  <= acc_sel;
        sat1  <= sat_en;
      end
    end
  end

  mac_sat_add #(
    .ACC_W (ACC_W),
    .PROD_W(PROD_W)
  ) u_sat_add (
    .acc   (acc_q[sel1]),
    .prod  (prod1),
    .sat_en(sat1),
    .sum   (sum2)
  );

  assign drain_fire = drain_valid && drain_ready;

  // Stage 2 and drain-clear never coincide: drain only runs after FLUSH has seen v1 low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
      acc_out   <= '0;
      valid_out <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
      acc_out   <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= v1;
      if (v1) begin
        acc_q[sel1] <= sum2;
        acc_out     <= sum2;
      end
      if ((CLR_ON_DRAIN != 0) && drain_fire) acc_q[cnt] <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      drain_valid <= 1'b0;
      busy        <= 1'b0;
    end else if (clear) begin
      state       <= IDLE;
      cnt         <= '0;
      drain_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (drain_start) begin
            state <= FLUSH;
            busy  <= 1'b1;
          end
        end
        FLUSH: begin
          if (!v1) begin
            state       <= DRAIN;
            drain_valid <= 1'b1;
            cnt         <= '0;
          end
        end
        DRAIN: begin
          if (drain_fire) begin
            if (cnt == LAST_IDX) begin
              state       <= IDLE;
              drain_valid <= 1'b0;
              busy        <= 1'b0;
              cnt         <= '0;
            end else begin
              cnt <= cnt + SEL_W'(1);
            end
          end
        end
        default: begin
          state       <= IDLE;
          drain_valid <= 1'b0;
          busy        <= 1'b0;
          cnt         <= '0;
        end
      endcase
    end
  end

  assign drain_idx  = cnt;
  assign drain_data = acc_q[cnt];

endmodule

// File: tb/tb_mac_pe_bank.sv
// Directed bench for mac_pe_bank (W=8, ACC_W=16, NUM_CH=3, NUM_ACC=8) with hand-computed expectations.
module tb_mac_pe_bank;

  logic               clk;
  logic               rst;
  logic [2:0]         valid_ctrl;
  logic [23:0]        a_in;
  logic signed [7:0]  weight;
  logic               weight_valid_in;
  logic [2:0]         acc_sel;
  logic               sat_en;
  logic               clear;
  logic               drain_start;
  logic               drain_ready;
  logic [23:0]        a_out;
  logic signed [15:0] acc_out;
  logic               valid_out;
  logic signed [15:0] drain_data;
  logic [2:0]         drain_idx;
  logic               drain_valid;
  logic               busy;

  int vectors     = 0;
  int miscompares = 0;

  mac_pe_bank #(
    .W(8), .ACC_W(16), .NUM_CH(3), .NUM_ACC(8), .CLR_ON_DRAIN(1)
  ) dut (
    .clk(clk), .rst(rst), .valid_ctrl(valid_ctrl), .a_in(a_in), .weight(weight),
    .weight_valid_in(weight_valid_in), .acc_sel(acc_sel), .sat_en(sat_en), .clear(clear),
    .drain_start(drain_start), .drain_ready(drain_ready), .a_out(a_out), .acc_out(acc_out),
    .valid_out(valid_out), .drain_data(drain_data), .drain_idx(drain_idx),
    .drain_valid(drain_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] vc, input logic signed [7:0] a2, input logic signed [7:0] a1,
                       input logic signed [7:0] a0, input logic signed [7:0] w, input logic wv,
                       input logic [2:0] sel, input logic sat);
    valid_ctrl      = vc;
    a_in            = {a2, a1, a0};
    weight          = w;
    weight_valid_in = wv;
    acc_sel         = sel;
    sat_en          = sat;
  endtask

  task automatic idle_in();
    valid_ctrl      = 3'b000;
    weight_valid_in = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if (acc_out !== 16'sd0 || valid_out !== 1'b0 || drain_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs acc_out=%0d valid_out=%b drain_valid=%b busy=%b exp 0", acc_out, valid_out, drain_valid, busy);
    end
    vectors++;
    if (a_out !== 24'h0 || drain_idx !== 3'd0 || drain_data !== 16'sd0) begin
      miscompares++;
      $display("FAIL reset_drain_aout a_out=%h drain_idx=%0d drain_data=%0d exp 0", a_out, drain_idx, drain_data);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    vectors++;
    if (a_out !== 24'h123456) begin
      miscompares++;
      $display("FAIL a_out_pass got=%h exp=123456", a_out);
    end
  endtask

  task automatic test_lane_priority();
    drive(3'b110, 8'sd5, 8'sd3, 8'sd9, 8'sd4, 1'b1, 3'd2, 1'b0);
    tick();
    vectors++;
    if (valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL t1_latency_early valid_out=%b exp=0", valid_out);
    end
    idle_in();
    tick();
    vectors++;
    if (valid_out !== 1'b1 || acc_out !== 16'sd12) begin
      miscompares++;
      $display("FAIL t1_lane1 valid_out=%b acc_out=%0d exp 1/12", valid_out, acc_out);
    end
    drive(3'b100, 8'sd5, 8'sd3, 8'sd9, 8'sd4, 1'b1, 3'd7, 1'b0);
    tick();
    idle_in();
    tick();
    vectors++;
    if (valid_out !== 1'b1 || acc_out !== 16'sd20) begin
      miscompares++;
      $display("FAIL t1_lane2 valid_out=%b acc_out=%0d exp 1/20", valid_out, acc_out);
    end
    tick();
    vectors++;
    if (valid_out !== 1'b0 || acc_out !== 16'sd20) begin
      miscompares++;
      $display("FAIL t1_hold valid_out=%b acc_out=%0d exp 0/20", valid_out, acc_out);
    end
  endtask

  task automatic test_saturate_wrap();
    drive(3'b001, 8'sd0, 8'sd0, 8'sd127, 8'sd127, 1'b1, 3'd0, 1'b1);
    tick();
    tick();
    vectors++;
    if (acc_out !== 16'sd16129) begin
      miscompares++;
      $display("FAIL t2_sat_step1 got=%0d exp=16129", acc_out);
    end
    tick();
    vectors++;
    if (acc_out !== 16'sd32258) begin
      miscompares++;
      $display("FAIL t2_sat_step2 got=%0d exp=32258", acc_out);
    end
    idle_in();
    tick();
    vectors++;
    if (acc_out !== 16'sd32767 || valid_out !== 1'b1) begin
      miscompares++;
      $display("FAIL t2_sat_final acc_out=%0d valid_out=%b exp 32767/1", acc_out, valid_out);
    end
    drive(3'b001, 8'sd0, 8'sd0, 8'sd127, 8'sd127, 1'b1, 3'd1, 1'b0);
    tick();
    tick();
    tick();
    vectors++;
    if (acc_out !== 16'sd32258) begin
      miscompares++;
      $display("FAIL t2_wrap_step2 got=%0d exp=32258", acc_out);
    end
    idle_in();
    tick();
    vectors++;
    if (acc_out !== -16'sd17149 || valid_out !== 1'b1) begin
      miscompares++;
      $display("FAIL t2_wrap_final acc_out=%0d valid_out=%b exp -17149/1", acc_out, valid_out);
    end
    tick();
  endtask

  task automatic test_flush_drain();
    logic signed [15:0] exp_d [8];
    int  k;
    int  guard;
    int  g;
    bit  r;
    exp_d = '{16'sd32761, -16'sd17149, 16'sd12, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd20};
    drive(3'b001, 8'sd0, 8'sd0, -8'sd2, 8'sd3, 1'b1, 3'd0, 1'b1);
    tick();
    idle_in();
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || drain_valid !== 1'b0 || valid_out !== 1'b1) begin
      miscompares++;
      $display("FAIL t3_flush busy=%b drain_valid=%b valid_out=%b exp 1/0/1", busy, drain_valid, valid_out);
    end
    tick();
    k     = 0;
    guard = 0;
    r     = 1'b1;
    while (k < 8 && guard < 40) begin
      drain_ready = r;
      vectors++;
      if (drain_valid !== 1'b1 || drain_idx !== 3'(k) || drain_data !== exp_d[k]) begin
        miscompares++;
        $display("FAIL t3_beat dv=%b idx=%0d data=%0d exp 1/%0d/%0d", drain_valid, drain_idx, drain_data, k, exp_d[k]);
      end
      tick();
      if (r) k++;
      r = !r;
      guard++;
    end
    drain_ready = 1'b0;
    vectors++;
    if (guard >= 40 || drain_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL t3_drain_end guard=%0d drain_valid=%b busy=%b exp <40/0/0", guard, drain_valid, busy);
    end
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    g = 0;
    while (!drain_valid && g < 8) begin
      tick();
      g++;
    end
    vectors++;
    if (drain_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL t3_redrain_timeout drain_valid=%b exp=1", drain_valid);
    end
    drain_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (drain_idx !== 3'(i) || drain_data !== 16'sd0) begin
        miscompares++;
        $display("FAIL t3_zero idx=%0d data=%0d exp %0d/0", drain_idx, drain_data, i);
      end
      tick();
    end
    drain_ready = 1'b0;
  endtask

  task automatic test_clear_mid_drain();
    int g;
    drive(3'b001, 8'sd0, 8'sd0, 8'sd10, 8'sd10, 1'b1, 3'd3, 1'b0);
    tick();
    drive(3'b010, 8'sd0, -8'sd3, 8'sd0, 8'sd7, 1'b1, 3'd5, 1'b0);
    tick();
    drive(3'b001, 8'sd0, 8'sd0, 8'sd4, -8'sd8, 1'b1, 3'd6, 1'b0);
    tick();
    idle_in();
    tick();
    vectors++;
    if (acc_out !== -16'sd32 || valid_out !== 1'b1) begin
      miscompares++;
      $display("FAIL t4_load acc_out=%0d valid_out=%b exp -32/1", acc_out, valid_out);
    end
    tick();
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    tick();
    drain_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (drain_valid !== 1'b1 || drain_idx !== 3'(i) || drain_data !== 16'sd0) begin
        miscompares++;
        $display("FAIL t4_beat dv=%b idx=%0d data=%0d exp 1/%0d/0", drain_valid, drain_idx, drain_data, i);
      end
      tick();
    end
    vectors++;
    if (drain_idx !== 3'd3 || drain_data !== 16'sd100) begin
      miscompares++;
      $display("FAIL t4_idx3 idx=%0d data=%0d exp 3/100", drain_idx, drain_data);
    end
    clear = 1'b1;
    tick();
    clear       = 1'b0;
    drain_ready = 1'b0;
    vectors++;
    if (drain_valid !== 1'b0 || busy !== 1'b0 || acc_out !== 16'sd0 || valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL t4_clear dv=%b busy=%b acc_out=%0d valid_out=%b exp 0/0/0/0", drain_valid, busy, acc_out, valid_out);
    end
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    g = 0;
    while (!drain_valid && g < 8) begin
      tick();
      g++;
    end
    vectors++;
    if (drain_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL t4_redrain_timeout drain_valid=%b exp=1", drain_valid);
    end
    drain_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (drain_idx !== 3'(i) || drain_data !== 16'sd0) begin
        miscompares++;
        $display("FAIL t4_zero idx=%0d data=%0d exp %0d/0", drain_idx, drain_data, i);
      end
      tick();
    end
    drain_ready = 1'b0;
  endtask

  task automatic test_weight_gate_and_reset();
    drive(3'b001, 8'sd0, 8'sd0, 8'sd2, 8'sd5, 1'b1, 3'd4, 1'b0);
    tick();
    idle_in();
    tick();
    vectors++;
    if (valid_out !== 1'b1 || acc_out !== 16'sd10) begin
      miscompares++;
      $display("FAIL t5_preload valid_out=%b acc_out=%0d exp 1/10", valid_out, acc_out);
    end
    drive(3'b001, 8'sd0, 8'sd0, -8'sd7, 8'sd9, 1'b0, 3'd4, 1'b0);
    tick();
    idle_in();
    tick();
    vectors++;
    if (valid_out !== 1'b1 || acc_out !== 16'sd10) begin
      miscompares++;
      $display("FAIL t5_wgate valid_out=%b acc_out=%0d exp 1/10", valid_out, acc_out);
    end
    drive(3'b001, 8'sd0, 8'sd0, 8'sd1, 8'sd1, 1'b1, 3'd4, 1'b0);
    tick();
    idle_in();
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (valid_out !== 1'b0 || acc_out !== 16'sd0 || busy !== 1'b0 || drain_valid !== 1'b0 || a_out !== 24'h0) begin
      miscompares++;
      $display("FAIL t5_async_rst valid_out=%b acc_out=%0d busy=%b dv=%b a_out=%h exp all 0", valid_out, acc_out, busy, drain_valid, a_out);
    end
    #2;
    rst = 1'b0;
    tick();
    vectors++;
    if (valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL t5_no_late_valid1 valid_out=%b exp=0", valid_out);
    end
    tick();
    vectors++;
    if (valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL t5_no_late_valid2 valid_out=%b exp=0", valid_out);
    end
    drive(3'b001, 8'sd0, 8'sd0, 8'sd1, 8'sd1, 1'b1, 3'd4, 1'b0);
    tick();
    idle_in();
    tick();
    vectors++;
    if (valid_out !== 1'b1 || acc_out !== 16'sd1) begin
      miscompares++;
      $display("FAIL t5_acc_reset valid_out=%b acc_out=%0d exp 1/1", valid_out, acc_out);
    end
  endtask

  initial begin
    rst             = 1'b1;
    clear           = 1'b0;
    drain_start     = 1'b0;
    drain_ready     = 1'b0;
    valid_ctrl      = 3'b000;
    a_in            = 24'h123456;
    weight          = 8'sd0;
    weight_valid_in = 1'b1;
    acc_sel         = 3'd0;
    sat_en          = 1'b0;
    test_reset();
    test_lane_priority();
    test_saturate_wrap();
    test_flush_drain();
    test_clear_mid_drain();
    test_weight_gate_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

endmodule
